// File: rtl/mb_event_queue_if.sv
// Handshake bundle for mb_event_queue: post/get/clear requests in, queue status out.
// The master side drives requests; the slave side (the queue) drives status.
interface mb_event_queue_if #(
    parameter int EVENT_W = 3,
    parameter int CNT_W   = 3
);
    logic               inPostValid;
    logic [EVENT_W-1:0] inPostEvent;
    logic               inGetReq;
    logic               inClrOverflow;
    logic               outEventInQueue;
    logic [EVENT_W-1:0] outEvent;
    logic               outEventHappened;
    logic [EVENT_W-1:0] outGotEvent;
    logic [CNT_W-1:0]   outCount;
    logic               outFull;
    logic               outOverflow;

    modport master (
        output inPostValid, inPostEvent, inGetReq, inClrOverflow,
        input  outEventInQueue, outEvent, outEventHappened, outGotEvent,
        input  outCount, outFull, outOverflow
    );

    modport slave (
        input  inPostValid, inPostEvent, inGetReq, inClrOverflow,
        output outEventInQueue, outEvent, outEventHappened, outGotEvent,
        output outCount, outFull, outOverflow
    );
endinterface

// File: rtl/mb_event_queue.sv
// Circular event queue with optional coalescing of repeated posts and a sticky overflow flag.
// All status outputs come straight from registers; the head register is precomputed each cycle.
module mb_event_queue #(
    parameter int EVENT_W  = 3,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3,
    parameter bit COALESCE = 1'b0,
    parameter int EV_READY = 0
) (
    input logic clk,
    input logic rst_n,
    mb_event_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [EVENT_W-1:0] READY_CODE = EVENT_W'(EV_READY);
    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);

    logic [EVENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [EVENT_W-1:0] newest;
    logic [EVENT_W-1:0] head;
    logic [EVENT_W-1:0] head_next;
    logic [EVENT_W-1:0] got_event;
    logic               get_ok;
    logic               post_ok;
    logic               merge;
    logic               drop;
    logic               in_queue;
    logic               full;
    logic               happened;
    logic               overflow;

    always_comb begin
        get_ok      = bus.inGetReq && (count != '0);
        newest      = mem[wr_ptr - PTR_W'(1)];
        // Merging is off when the only entry is leaving this cycle, otherwise the post would vanish.
        merge       = COALESCE && bus.inPostValid && (count != '0) &&
                      (bus.inPostEvent == newest) && !((count == CNT_W'(1)) && get_ok);
        post_ok     = bus.inPostValid && !merge && ((count != FULL_CNT) || get_ok);
        drop        = bus.inPostValid && !merge && (count == FULL_CNT) && !get_ok;
        rd_ptr_next = get_ok ? rd_ptr + PTR_W'(1) : rd_ptr;

        count_next = count;
        if (post_ok && !get_ok) begin
            count_next = count + CNT_W'(1);
        end else if (get_ok && !post_ok) begin
            count_next = count - CNT_W'(1);
        end

        // When the slot being written is the next head, storage is not yet updated, so forward the post.
        head_next = READY_CODE;
        if (count_next != '0) begin
            head_next = (post_ok && (wr_ptr == rd_ptr_next)) ? bus.inPostEvent : mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (post_ok) begin
            mem[wr_ptr] <= bus.inPostEvent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head      <= READY_CODE;
            got_event <= READY_CODE;
            in_queue  <= 1'b0;
            full      <= 1'b0;
            happened  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (post_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            head     <= head_next;
            in_queue <= (count_next != '0);
            full     <= (count_next == FULL_CNT);
            happened <= get_ok;
            if (get_ok) begin
                got_event <= head;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.inClrOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.outEventInQueue  = in_queue;
    assign bus.outEvent         = head;
    assign bus.outEventHappened = happened;
    assign bus.outGotEvent      = got_event;
    assign bus.outCount         = count;
    assign bus.outFull          = full;
    assign bus.outOverflow      = overflow;
endmodule

// File: doc/mb_event_queue.md
MB_EVENT_QUEUE -- requirements
Module: mb_event_queue

Interface
REQ-001 Parameter EVENT_W, default 3, width of one event code.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-003 Parameter CNT_W, default 3, occupancy width, equal to log2(DEPTH)+1.
REQ-004 Parameter COALESCE, default 0; when 1, a post equal to the newest queued event is merged.
REQ-005 Parameter EV_READY, default 0, event code reported while the queue is empty.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 inPostValid  input  1  post request, one event per cycle.
REQ-009 inPostEvent  input  EVENT_W  event code to post.
REQ-010 inGetReq  input  1  consume head event.
REQ-011 inClrOverflow  input  1  clear sticky overflow.
REQ-012 outEventInQueue  output  1  high when count > 0.
REQ-013 outEvent  output  EVENT_W  head event; EV_READY when empty.
REQ-014 outEventHappened  output  1  one-cycle pulse, cycle after an accepted get.
REQ-015 outGotEvent  output  EVENT_W  event consumed by the last accepted get; valid while outEventHappened is high, holds otherwise.
REQ-016 outCount  output  CNT_W  occupancy, 0..DEPTH.
REQ-017 outFull  output  1  high when count == DEPTH.
REQ-018 outOverflow  output  1  sticky, a post was dropped because the queue was full.

Function
REQ-019 Circular buffer with write and read pointers of log2(DEPTH) bits; pointers wrap DEPTH-1 -> 0.
REQ-020 Get is accepted when inGetReq is high and count > 0; a get on empty is ignored and does not pulse outEventHappened.
REQ-021 Post is accepted when inPostValid is high and (count < DEPTH or a get is accepted in the same cycle), unless merged per REQ-023.
REQ-022 Simultaneous post and get on empty: post is stored, get is ignored (no bypass); count becomes 1.
REQ-023 COALESCE=1: a post whose code equals the newest stored entry is dropped silently (no count change, no overflow); merging is disabled when count == 1 and a get is accepted that cycle.
REQ-024 Post when full with no accepted get: event dropped, contents unchanged, outOverflow set next cycle.
REQ-025 outOverflow clears on inClrOverflow; a new overflow in the same cycle wins (stays 1).
REQ-026 Count updates: +1 on post only, -1 on get only, unchanged on both; never exceeds DEPTH or goes below 0.
REQ-027 outEvent, outEventInQueue, outFull and outCount are driven from registers only, with no combinational path from any input.
REQ-028 outEvent reflects a newly posted event in the cycle after the post when the queue was empty.
REQ-029 FIFO order is preserved across pointer wrap-around.

Reset
REQ-030 On rst_n low, immediately: pointers 0, count 0, outEventInQueue 0, outEvent EV_READY, outEventHappened 0, outGotEvent EV_READY, outFull 0, outOverflow 0.
REQ-031 Reset during operation discards all queued events; storage contents need not be cleared.
REQ-032 After reset release, the first edge accepts posts and gets normally.

Verification
REQ-033 Post 1,2,3 on consecutive cycles, then get x3 -> outGotEvent 1,2,3 in order, each with a one-cycle outEventHappened; final outCount 0, outEvent 0.
REQ-034 DEPTH=4: post 5 events with no gets -> outFull 1, outCount 4, outOverflow 1; fifth event absent on readout; inClrOverflow -> outOverflow 0.
REQ-035 Full queue, post 7 and get in the same cycle -> outCount stays 4, no overflow, 7 is read last.
REQ-036 COALESCE=1: post 2,2,3,3 -> outCount 2, reads 2 then 3; count 1 (2 queued), post 2 with get in the same cycle -> outCount 1, head 2.
REQ-037 Empty queue, post and get in the same cycle -> no outEventHappened, outCount 1; then assert rst_n low mid-stream -> all outputs at reset values asynchronously.
REQ-038 Run 3*DEPTH post/get pairs to exercise wrap-around -> order preserved and count consistent throughout.
